// File: rtl/and_gate.sv
// -----------------------------------------------------------------------------
// and_gate
//   3-input AND leaf cell used as a glue-logic enable combiner.
//   y is purely combinational (a & b & c); rst and clk have no effect on it.
//   A clocked sideband feeds debug/status registers:
//     y_q    - y sampled on posedge clk (1 cycle latency)
//     y_rise - registered one-cycle pulse on a 0->1 change of sampled y
//     y_cnt  - saturating count of posedges that sampled y == 1
//     y_sat  - high while y_cnt is all-ones
//
// Ports
//   clk    in   1      single clock, all flops on posedge
//   rst    in   1      synchronous, active-high reset
//   a,b,c  in   1      operands
//   y      out  1      a & b & c
//   y_q    out  1      registered y
//   y_rise out  1      registered rising-edge pulse of y
//   y_cnt  out  CNT_W  saturating true-cycle count
//   y_sat  out  1      y_cnt == all-ones
//
// Parameters
//   CNT_W  width of y_cnt, legal 1..32
//
// Build option
//   AND_GATE_STATS_EN  defined: y_cnt/y_sat counter implemented.
//                      undefined: counter omitted, y_cnt = 0, y_sat = 0.
// -----------------------------------------------------------------------------
module and_gate #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a,
    input  logic             b,
    input  logic             c,
    output logic             y,
    output logic             y_q,
    output logic             y_rise,
    output logic [CNT_W-1:0] y_cnt,
    output logic             y_sat
);

    logic y_d;
    logic rise_d;
    logic rise_q;

    // Plain AND keeps X propagation: an X with no 0 input yields X.
    assign y = a & b & c;

    always_comb begin
        y_d    = y;
        // y_q holds the previous sample, so this fires on the first 1 after reset.
        rise_d = y & ~y_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            y_q    <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            y_q    <= y_d;
            rise_q <= rise_d;
        end
    end

    assign y_rise = rise_q;

`ifdef AND_GATE_STATS_EN
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        // Hold at all-ones rather than wrapping back to zero.
        if (y && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign y_cnt = cnt_q;
    assign y_sat = (cnt_q == CNT_MAX);
`else
    assign y_cnt = '0;
    assign y_sat = 1'b0;
`endif

endmodule

// File: tb/tb_and_gate.sv
// -----------------------------------------------------------------------------
// tb_and_gate
//   Directed plus random stimulus for and_gate (CNT_W = 4). Expected values
//   come from a cycle-level model built on integers: last sampled y, a pulse
//   flag and a counter clamped with min(). Counter expectations follow the
//   AND_GATE_STATS_EN build option.
// -----------------------------------------------------------------------------
module tb_and_gate;

    localparam int unsigned CNT_W   = 4;
    localparam int          CNT_MAX = (1 << CNT_W) - 1;

    logic             clk;
    logic             clk_en;
    logic             rst;
    logic             a;
    logic             b;
    logic             c;
    logic             y;
    logic             y_q;
    logic             y_rise;
    logic [CNT_W-1:0] y_cnt;
    logic             y_sat;

    int n_checks;
    int n_err;
    int rise_seen;

    // reference model state
    bit m_yq;
    bit m_rise;
    int m_cnt;

    and_gate #(.CNT_W(CNT_W)) dut (
        .clk    (clk),
        .rst    (rst),
        .a      (a),
        .b      (b),
        .c      (c),
        .y      (y),
        .y_q    (y_q),
        .y_rise (y_rise),
        .y_cnt  (y_cnt),
        .y_sat  (y_sat)
    );

    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic int exp_cnt();
`ifdef AND_GATE_STATS_EN
        return m_cnt;
`else
        return 0;
`endif
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".y"},      32'(y),      32'(a & b & c));
        chk({tag, ".y_q"},    32'(y_q),    32'(m_yq));
        chk({tag, ".y_rise"}, 32'(y_rise), 32'(m_rise));
        chk({tag, ".y_cnt"},  32'(y_cnt),  32'(exp_cnt()));
        chk({tag, ".y_sat"},  32'(y_sat),  32'((exp_cnt() == CNT_MAX) ? 1 : 0));
    endtask

    // One clock: sample inputs as the DUT sees them at the edge, advance the
    // model, then compare 1 ns after the edge.
    task automatic tick(input string tag);
        bit yv;
        bit r;
        yv = bit'(a & b & c);
        r  = bit'(rst);
        @(posedge clk);
        if (r) begin
            m_yq   = 1'b0;
            m_rise = 1'b0;
            m_cnt  = 0;
        end else begin
            m_rise = yv && !m_yq;
            m_yq   = yv;
            if (yv) m_cnt = (m_cnt + 1 > CNT_MAX) ? CNT_MAX : m_cnt + 1;
        end
        #1;
        if (y_rise === 1'b1) rise_seen++;
        check_all(tag);
    endtask

    task automatic set_abc(input logic [2:0] v);
        {a, b, c} = v;
    endtask

    initial begin
        n_checks  = 0;
        n_err     = 0;
        rise_seen = 0;
        m_yq      = 1'b0;
        m_rise    = 1'b0;
        m_cnt     = 0;
        clk       = 1'b0;
        clk_en    = 1'b0;
        rst       = 1'b0;
        set_abc(3'b000);

        // truth table with the clock idle
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            set_abc(v);
            #10;
            chk($sformatf("tt_%0d", i), 32'(y), (i == 7) ? 32'd1 : 32'd0);
        end

        // X propagation: X with no 0 gives X, any 0 forces 0
        a = 1'bx; b = 1'b1; c = 1'b1;
        #1;
        chk("x_no_zero", 32'(y), {31'b0, 1'bx});
        b = 1'b0;
        #1;
        chk("x_with_zero", 32'(y), 32'd0);

        // synchronous reset for two clocks with y = 1
        clk_en = 1'b1;
        rst    = 1'b1;
        set_abc(3'b111);
        tick("rst1");
        tick("rst2");
        chk("rst_y_high", 32'(y), 32'd1);

        // rise pulse: 000 then 111 held three clocks
        rst = 1'b0;
        set_abc(3'b000);
        tick("low");
        rise_seen = 0;
        set_abc(3'b111);
        tick("rise1");
        chk("rise_first_cycle", 32'(y_rise), 32'd1);
        tick("rise2");
        chk("yq_after_one", 32'(y_q), 32'd1);
        tick("rise3");
        chk("rise_count", 32'(rise_seen), 32'd1);

        // input change between edges only moves y
        set_abc(3'b011);
        #2;
        chk("mid_y", 32'(y), 32'd0);
        chk("mid_yq_hold", 32'(y_q), 32'd1);
        set_abc(3'b111);

        // hold y = 1 for 20 clocks: counter must clamp
        for (int i = 0; i < 20; i++) tick("sat");
`ifdef AND_GATE_STATS_EN
        chk("sat_cnt", 32'(y_cnt), 32'(CNT_MAX));
        chk("sat_flag", 32'(y_sat), 32'd1);
`else
        chk("nostats_cnt", 32'(y_cnt), 32'd0);
        chk("nostats_sat", 32'(y_sat), 32'd0);
`endif

        // mid-run reset with y = 1 wins over the count
        rst = 1'b1;
        tick("mr_pre");
        rst = 1'b0;
        for (int i = 0; i < 5; i++) tick("mr_cnt");
        rst = 1'b1;
        tick("mr_rst");
        chk("mr_cleared", 32'(y_cnt), 32'd0);
        rst = 1'b0;
        tick("mr_restart");
        chk("mr_restart_cnt", 32'(y_cnt), 32'(exp_cnt()));

        // random traffic, biased toward y = 1, with occasional resets
        for (int i = 0; i < 400; i++) begin
            logic [2:0] v;
            v = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 0) v = 3'b111;
            set_abc(v);
            rst = ($urandom_range(0, 39) == 0);
            tick("rnd");
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
